// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// LSB digit first, start/busy/done handshake, C/V/Z flags.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             C,
  output logic             V,
  output logic             Zf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH ||
        (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_addsub: illegal WIDTH/DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]       a_sr, b_sr, acc, acc_n;
  logic [WIDTH+DIGIT-1:0] acc_w;
  logic                   cy;
  logic [CW-1:0]          cnt;
  logic                   accept, last;
  logic [DIGIT-1:0]       dsum;
  logic                   dcout, dcmsb;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));

  // ripple one digit; keep the carry into its top bit for V
  always_comb begin
    logic c;
    c     = cy;
    dsum  = '0;
    dcmsb = cy;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i] = a_sr[i] ^ b_sr[i] ^ c;
      if (i == DIGIT - 1) dcmsb = c;
      c = (a_sr[i] & b_sr[i]) | (c & (a_sr[i] ^ b_sr[i]));
    end
    dcout = c;
  end

  assign acc_w = {dsum, acc};
  assign acc_n = acc_w[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == IDLE): if (start) state_n = RUN;
      (state == RUN):  if (last)  state_n = DONE;
      (state == DONE): state_n = start ? RUN : IDLE;
      default:         state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      acc  <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      z    <= '0;
      C    <= 1'b0;
      V    <= 1'b0;
      Zf   <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B ^ {WIDTH{M}};
      cy   <= M;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> DIGIT;
      b_sr <= b_sr >> DIGIT;
      cy   <= dcout;
      acc  <= acc_n;
      cnt  <= cnt + CW'(1);
      if (last) begin
        z  <= acc_n;
        C  <= dcout;
        V  <= dcmsb ^ dcout;
        Zf <= (acc_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: five configs in lockstep,
// checked against an integer arithmetic model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       M = 1'b0;

  wire [4:0] bz, dn, cc, vv, zf;
  wire [7:0] z0, z1, z2, z3;
  wire [3:0] z4;

  int checks = 0;
  int errors = 0;

  localparam int WD[5] = '{8, 8, 8, 8, 4};
  localparam int NN[5] = '{4, 8, 2, 1, 4};

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .M(M),
    .busy(bz[0]), .done(dn[0]), .z(z0), .C(cc[0]), .V(vv[0]), .Zf(zf[0]));
  serial_addsub #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .M(M),
    .busy(bz[1]), .done(dn[1]), .z(z1), .C(cc[1]), .V(vv[1]), .Zf(zf[1]));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .M(M),
    .busy(bz[2]), .done(dn[2]), .z(z2), .C(cc[2]), .V(vv[2]), .Zf(zf[2]));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .M(M),
    .busy(bz[3]), .done(dn[3]), .z(z3), .C(cc[3]), .V(vv[3]), .Zf(zf[3]));
  serial_addsub #(.WIDTH(4), .DIGIT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A[3:0]), .B(B[3:0]), .M(M),
    .busy(bz[4]), .done(dn[4]), .z(z4), .C(cc[4]), .V(vv[4]), .Zf(zf[4]));

  function automatic logic [7:0] zof(input int i);
    case (i)
      0:       return z0;
      1:       return z1;
      2:       return z2;
      3:       return z3;
      default: return {4'b0, z4};
    endcase
  endfunction

  // plain integer arithmetic: wrap, unsigned carry, signed range
  function automatic void model(input int w, input logic [7:0] a,
                                input logic [7:0] b, input logic m,
                                output logic [7:0] ez, output logic ec,
                                output logic ev);
    int mask, ua, ub, sa, sb, r, sr;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    r  = m ? ua - ub : ua + ub;
    ez = 8'(r & mask);
    ec = m ? (ua >= ub) : (ua + ub > mask);
    sr = m ? sa - sb : sa + sb;
    ev = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input logic m, input bit scramble);
    int         lat[5];
    logic [7:0] zr[5];
    logic       cr[5], vr[5], fr[5];
    logic [7:0] ez;
    logic       ec, ev;
    int         bcnt;
    @(negedge clk);
    A = a; B = b; M = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 5; i++) lat[i] = 0;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (scramble && (cyc == 1 || cyc == 2)) begin
        A = 8'($urandom); B = 8'($urandom); M = 1'($urandom);
      end
      if (bz[0]) bcnt++;
      for (int i = 0; i < 5; i++)
        if (dn[i] && lat[i] == 0) begin
          lat[i] = cyc;
          zr[i] = zof(i); cr[i] = cc[i]; vr[i] = vv[i]; fr[i] = zf[i];
        end
    end
    chk("busy_cycles", bcnt, 4);
    for (int i = 0; i < 5; i++) begin
      model(WD[i], a, b, m, ez, ec, ev);
      chk($sformatf("lat[%0d]", i), lat[i], NN[i]);
      chk($sformatf("z[%0d] %h%s%h", i, a, m ? "-" : "+", b), zr[i], ez);
      chk($sformatf("C[%0d]", i), cr[i], ec);
      chk($sformatf("V[%0d]", i), vr[i], ev);
      chk($sformatf("Zf[%0d]", i), fr[i], ez == 8'h00);
    end
  endtask

  initial begin
    logic [7:0] qa[$], qb[$];
    logic       qm[$];
    logic [7:0] ez, ta, tb;
    logic       ec, ev, tm;
    bit         seen;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bz, 5'b0);
    chk("rst_done", dn, 5'b0);
    chk("rst_z", z0, 8'h00);
    chk("rst_C", cc, 5'b0);
    chk("rst_V", vv, 5'b0);
    chk("rst_Zf", zf, 5'b0);
    rst_n = 1'b1;

    op(8'h01, 8'h01, 1'b0, 0);
    chk("t1_z", z0, 8'h02);
    op(8'h7F, 8'h01, 1'b0, 0);
    chk("t2_V", vv[0], 1'b1);
    op(8'hFF, 8'h01, 1'b0, 0);
    chk("t2_Zf", zf[0], 1'b1);
    op(8'h07, 8'h05, 1'b1, 0);
    op(8'h05, 8'h07, 1'b1, 0);
    chk("t3_z", z0, 8'hFE);
    op(8'h80, 8'h01, 1'b1, 0);
    chk("t3_CV", {cc[0], vv[0]}, 2'b11);

    // operands disturbed while running
    op(8'h3C, 8'h5A, 1'b1, 1);
    op(8'hA5, 8'h96, 1'b0, 1);

    // reset two cycles into an operation
    @(negedge clk);
    A = 8'h55; B = 8'h22; M = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bz, 5'b0);
    chk("mid_rst_done", dn, 5'b0);
    chk("mid_rst_z", z0, 8'h00);
    chk("mid_rst_flags", {cc[0], vv[0], zf[0]}, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (dn[0]) seen = 1;
    end
    chk("mid_rst_no_done", seen, 1'b0);
    op(8'h10, 8'h20, 1'b0, 0);
    chk("post_rst_z", z0, 8'h30);

    // start held high: accepted every N+1 cycles
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      A = 8'($urandom); B = 8'($urandom); M = 1'($urandom);
      start = 1'b1;
      if (t % 5 == 0) begin
        qa.push_back(A); qb.push_back(B); qm.push_back(M);
      end
      @(posedge clk);
      #1;
      chk($sformatf("bb_done t=%0d", t), dn[0], (t % 5) == 4);
      if (dn[0] && qa.size() > 0) begin
        ta = qa.pop_front(); tb = qb.pop_front(); tm = qm.pop_front();
        model(8, ta, tb, tm, ez, ec, ev);
        chk("bb_z", z0, ez);
        chk("bb_C", cc[0], ec);
        chk("bb_V", vv[0], ev);
      end
    end
    chk("bb_drained", qa.size(), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);

    for (int k = 0; k < 1000; k++)
      op(8'($urandom), 8'($urandom), 1'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
